// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// uart_rx_framed : oversampling UART receiver with parity/framing/break status
//                  and a valid/ready holding register with overrun pulse.
// Revision 1.0
// ============================================================================
module uart_rx_framed #(
  parameter int Oversample = 16,
  parameter int DataBits   = 8,
  parameter int Parity     = 0,
  parameter int StopBits   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in,
  output logic [DataBits-1:0] data,
  output logic                outValid,
  input  logic                outReady,
  output logic                parityErr,
  output logic                frameErr,
  output logic                overrun,
  output logic                brk
);

  localparam int              c_cntW     = $clog2(Oversample);
  localparam logic [c_cntW-1:0] c_cntLoad = c_cntW'(Oversample - 1);
  localparam logic [c_cntW-1:0] c_cntMid  = c_cntW'(Oversample / 2);
  localparam logic [3:0]      c_lastData = 4'(DataBits - 1);
  localparam logic [3:0]      c_lastStop = 4'(StopBits - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_sync1;
  logic                  r_rxs;
  logic                  r_rxsD;
  logic [c_cntW-1:0]     r_cnt;
  logic [3:0]            r_bitIdx;
  logic [DataBits-1:0]   r_shift;
  logic                  r_parAcc;
  logic                  r_parErrI;
  logic                  r_frameErrI;
  logic                  r_anyOne;

  logic w_edge, w_fall, w_mid, w_end, w_inBit, w_resync, w_bitEnd;
  logic w_done, w_enterBrk, w_frameErrNow;

  assign w_edge        = r_rxs ^ r_rxsD;
  assign w_fall        = r_rxsD & ~r_rxs;
  assign w_mid         = (r_cnt == c_cntMid);
  assign w_end         = (r_cnt == '0);
  assign w_inBit       = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
  // An early edge in the second half of a bit means the transmitter runs fast.
  assign w_resync      = w_inBit && w_edge && (r_cnt < c_cntMid);
  assign w_bitEnd      = w_end || w_resync;
  assign w_frameErrNow = r_frameErrI | ~r_rxs;

  always_comb begin
    w_next     = r_state;
    w_done     = 1'b0;
    w_enterBrk = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START: begin
        if (w_mid && r_rxs) w_next = S_IDLE;
        else if (w_end)     w_next = S_DATA;
      end
      S_DATA: begin
        if (w_bitEnd && (r_bitIdx == c_lastData))
          w_next = (Parity != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_bitEnd) w_next = S_STOP;
      S_STOP: begin
        // Completing at the last mid-bit lets the next start edge be seen at once.
        if (w_mid && (r_bitIdx == c_lastStop)) begin
          if (!(r_anyOne | r_rxs)) begin
            w_next     = S_BREAK;
            w_enterBrk = 1'b1;
          end else begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end
        end
      end
      S_BREAK:  if (r_rxs) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_rxs       <= 1'b1;
      r_rxsD      <= 1'b1;
      r_cnt       <= c_cntLoad;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_parAcc    <= 1'b0;
      r_parErrI   <= 1'b0;
      r_frameErrI <= 1'b0;
      r_anyOne    <= 1'b0;
      data        <= '0;
      outValid    <= 1'b0;
      parityErr   <= 1'b0;
      frameErr    <= 1'b0;
      overrun     <= 1'b0;
      brk         <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_rxs   <= r_sync1;
      r_rxsD  <= r_rxs;
      r_state <= w_next;

      if ((w_next != r_state) || w_resync || w_end) r_cnt <= c_cntLoad;
      else                                          r_cnt <= r_cnt - 1'b1;

      if (w_next != r_state)       r_bitIdx <= '0;
      else if (w_inBit && w_bitEnd) r_bitIdx <= r_bitIdx + 4'd1;

      if ((r_state == S_IDLE) && w_fall) begin
        r_parAcc    <= 1'b0;
        r_parErrI   <= 1'b0;
        r_frameErrI <= 1'b0;
        r_anyOne    <= 1'b0;
      end

      if (w_mid) begin
        case (r_state)
          S_DATA: begin
            r_shift  <= {r_rxs, r_shift[DataBits-1:1]};
            r_parAcc <= r_parAcc ^ r_rxs;
            r_anyOne <= r_anyOne | r_rxs;
          end
          S_PARITY: begin
            r_parErrI <= (Parity == 1) ? (r_parAcc ^ r_rxs) : ~(r_parAcc ^ r_rxs);
            r_anyOne  <= r_anyOne | r_rxs;
          end
          S_STOP: begin
            r_frameErrI <= r_frameErrI | ~r_rxs;
            r_anyOne    <= r_anyOne | r_rxs;
          end
          default: ;
        endcase
      end

      if (w_done && (!outValid || outReady)) begin
        data      <= r_shift;
        parityErr <= r_parErrI;
        frameErr  <= w_frameErrNow;
        outValid  <= 1'b1;
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end

      overrun <= w_done && outValid && !outReady;
      brk     <= w_enterBrk;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_framed : directed checks of uart_rx_framed across four configs.
// Revision 1.0
// ============================================================================
module tb_uart_rx_framed;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] lineIn = 4'hF;
  logic [3:0] rdy = 4'h0;
  logic [7:0] data0, data1;
  logic [4:0] data2;
  logic [8:0] data3;
  logic [3:0] vld, pe, fe, ovr, brkP;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  // u0: even parity, u1: odd parity, u2: 5 bits 2 stops, u3: 9 bits odd parity x8
  uart_rx_framed #(.Oversample(16), .DataBits(8), .Parity(1), .StopBits(1)) u0 (
    .clk(clk), .reset(reset), .in(lineIn[0]), .data(data0), .outValid(vld[0]),
    .outReady(rdy[0]), .parityErr(pe[0]), .frameErr(fe[0]), .overrun(ovr[0]), .brk(brkP[0]));
  uart_rx_framed #(.Oversample(16), .DataBits(8), .Parity(2), .StopBits(1)) u1 (
    .clk(clk), .reset(reset), .in(lineIn[1]), .data(data1), .outValid(vld[1]),
    .outReady(rdy[1]), .parityErr(pe[1]), .frameErr(fe[1]), .overrun(ovr[1]), .brk(brkP[1]));
  uart_rx_framed #(.Oversample(16), .DataBits(5), .Parity(0), .StopBits(2)) u2 (
    .clk(clk), .reset(reset), .in(lineIn[2]), .data(data2), .outValid(vld[2]),
    .outReady(rdy[2]), .parityErr(pe[2]), .frameErr(fe[2]), .overrun(ovr[2]), .brk(brkP[2]));
  uart_rx_framed #(.Oversample(8), .DataBits(9), .Parity(2), .StopBits(1)) u3 (
    .clk(clk), .reset(reset), .in(lineIn[3]), .data(data3), .outValid(vld[3]),
    .outReady(rdy[3]), .parityErr(pe[3]), .frameErr(fe[3]), .overrun(ovr[3]), .brk(brkP[3]));

  logic [8:0] wData [4];
  assign wData[0] = {1'b0, data0};
  assign wData[1] = {1'b0, data1};
  assign wData[2] = {4'b0, data2};
  assign wData[3] = data3;

  int         nAcc [4] = '{default: 0};
  int         nBrk [4] = '{default: 0};
  int         nOvr [4] = '{default: 0};
  logic [8:0] capData [4];
  logic       capPE [4];
  logic       capFE [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && rdy[i]) begin
        nAcc[i]    <= nAcc[i] + 1;
        capData[i] <= wData[i];
        capPE[i]   <= pe[i];
        capFE[i]   <= fe[i];
      end
      if (brkP[i]) nBrk[i] <= nBrk[i] + 1;
      if (ovr[i])  nOvr[i] <= nOvr[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bitOut(input int inst, input logic v, input int n);
    lineIn[inst] = v;
    repeat (n) @(negedge clk);
  endtask

  // parBit < 0 means no parity bit; stops[k] is the level of stop bit k.
  task automatic sendFrame(input int inst, input logic [8:0] word, input int nData,
                           input int parBit, input int nStop, input logic [1:0] stops,
                           input int bitLen, input bit jitter);
    logic [15:0] bits;
    int nb;
    bits = '0;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < nData; i++) begin bits[nb] = word[i]; nb++; end
    if (parBit >= 0) begin bits[nb] = parBit[0]; nb++; end
    for (int k = 0; k < nStop; k++) begin bits[nb] = stops[k]; nb++; end
    for (int b = 0; b < nb; b++)
      bitOut(inst, bits[b], jitter ? bitLen + (((b % 2) == 1) ? 1 : -1) : bitLen);
    bitOut(inst, 1'b1, 2 * bitLen);
  endtask

  initial begin
    int a0, b0, o0;
    logic [8:0] w;
    int pb;
    logic expPE;

    repeat (4) @(negedge clk);
    check("reset_u0_outputs", {22'b0, data0, vld[0], pe[0], fe[0], ovr[0], brkP[0]}, 32'h0);
    check("reset_u3_outputs", {18'b0, data3, vld[3], pe[3], fe[3], ovr[3], brkP[3]}, 32'h0);
    reset = 1'b0;
    rdy = 4'hF;
    repeat (4) @(negedge clk);

    // Basic receive and parity errors
    a0 = nAcc[0];
    sendFrame(0, 9'h0A5, 8, 0, 1, 2'b11, 16, 1'b0);
    check("basic_count", nAcc[0] - a0, 1);
    check("basic_data", capData[0], 9'h0A5);
    check("basic_flags", {capPE[0], capFE[0]}, 2'b00);
    sendFrame(0, 9'h0A5, 8, 1, 1, 2'b11, 16, 1'b0);
    check("parerr_data", capData[0], 9'h0A5);
    check("parerr_flag", capPE[0], 1'b1);
    sendFrame(1, 9'h0A5, 8, 1, 1, 2'b11, 16, 1'b0);
    check("odd_ok_data", capData[1], 9'h0A5);
    check("odd_ok_flag", capPE[1], 1'b0);

    // Framing error held in the register, then a break
    rdy[0] = 1'b0;
    sendFrame(0, 9'h03C, 8, 0, 1, 2'b10, 16, 1'b0);
    check("frame_valid", vld[0], 1'b1);
    check("frame_data", data0, 8'h3C);
    check("frame_ferr", fe[0], 1'b1);
    b0 = nBrk[0];
    o0 = nOvr[0];
    bitOut(0, 1'b0, 12 * 16);
    bitOut(0, 1'b1, 32);
    check("break_pulses", nBrk[0] - b0, 1);
    check("break_no_overrun", nOvr[0] - o0, 0);
    check("break_valid_kept", vld[0], 1'b1);
    check("break_data_kept", data0, 8'h3C);
    rdy[0] = 1'b1;
    @(negedge clk);
    check("drain_valid_low", vld[0], 1'b0);
    sendFrame(0, 9'h055, 8, 0, 1, 2'b11, 16, 1'b0);
    check("after_break_data", capData[0], 9'h055);
    check("after_break_flags", {capPE[0], capFE[0]}, 2'b00);

    // Overrun
    rdy[0] = 1'b0;
    o0 = nOvr[0];
    sendFrame(0, 9'h011, 8, 0, 1, 2'b11, 16, 1'b0);
    sendFrame(0, 9'h022, 8, 0, 1, 2'b11, 16, 1'b0);
    check("overrun_pulses", nOvr[0] - o0, 1);
    check("overrun_data_kept", data0, 8'h11);
    check("overrun_valid", vld[0], 1'b1);
    rdy[0] = 1'b1;
    @(negedge clk);
    check("overrun_drain", vld[0], 1'b0);

    // Glitch in idle
    a0 = nAcc[0];
    b0 = nBrk[0];
    bitOut(0, 1'b0, 4);
    bitOut(0, 1'b1, 48);
    check("glitch_no_frame", nAcc[0] - a0, 0);
    check("glitch_no_brk", nBrk[0] - b0, 0);
    check("glitch_valid", vld[0], 1'b0);

    // Alternating 15/17-cycle bits
    a0 = nAcc[0];
    sendFrame(0, 9'h096, 8, 0, 1, 2'b11, 16, 1'b1);
    check("jitter_count", nAcc[0] - a0, 1);
    check("jitter_data", capData[0], 9'h096);
    check("jitter_flags", {capPE[0], capFE[0]}, 2'b00);

    // Reset mid-DATA with a full holding register
    rdy[0] = 1'b0;
    sendFrame(0, 9'h081, 8, 0, 1, 2'b11, 16, 1'b0);
    check("pre_reset_valid", {vld[0], data0}, {1'b1, 8'h81});
    bitOut(0, 1'b0, 16 * 4);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset", {22'b0, data0, vld[0], pe[0], fe[0], ovr[0], brkP[0]}, 32'h0);
    reset = 1'b0;
    lineIn[0] = 1'b1;
    rdy[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_idle", vld[0], 1'b0);
    a0 = nAcc[0];
    sendFrame(0, 9'h0F0, 8, 0, 1, 2'b11, 16, 1'b0);
    check("post_reset_count", nAcc[0] - a0, 1);
    check("post_reset_data", capData[0], 9'h0F0);

    // 5 data bits, 2 stop bits, no parity; last word has a low second stop bit
    for (int i = 0; i < 6; i++) begin
      w = 9'($urandom_range(0, 31));
      a0 = nAcc[2];
      sendFrame(2, w, 5, -1, 2, (i == 5) ? 2'b01 : 2'b11, 16, 1'b0);
      check("d5_count", nAcc[2] - a0, 1);
      check("d5_data", capData[2], w);
      check("d5_flags", {capPE[2], capFE[2]}, {1'b0, (i == 5)});
    end

    // 9 data bits, odd parity, oversample 8; alternate good and bad parity bits
    for (int i = 0; i < 6; i++) begin
      w = 9'($urandom_range(0, 511));
      pb = ((i % 2) == 1) ? int'(~^w) : int'(^w);
      expPE = ~((^w) ^ pb[0]);
      a0 = nAcc[3];
      sendFrame(3, w, 9, pb, 1, 2'b11, 8, 1'b0);
      check("d9_count", nAcc[3] - a0, 1);
      check("d9_data", capData[3], w);
      check("d9_flags", {capPE[3], capFE[3]}, {expPE, 1'b0});
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
